// File: rtl/fp_iter_seq_ctrl.sv
// Sequencing controller for the iterative divide/sqrt mantissa datapaths:
// load, N iterate cycles, done pulse, with stall, flush and re-trigger hold.
module fp_iter_seq_ctrl #(
  parameter int ITERS_SQRT = 26,
  parameter int ITERS_DIV  = 27,
  parameter int CNT_W      = 8
) (
  input  logic             in_Clk,
  input  logic             in_Rst_N,
  input  logic             in_start,
  input  logic             in_mode,
  input  logic             in_flush,
  output logic             out_load,
  output logic             out_shift_en,
  output logic [CNT_W-1:0] out_iter_idx,
  output logic             out_busy,
  output logic             out_done,
  output logic             out_stall,
  output logic             out_mode
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_ITER = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_HOLD = 3'd4;

  localparam logic [CNT_W-1:0] LAST_SQRT = CNT_W'(ITERS_SQRT - 1);
  localparam logic [CNT_W-1:0] LAST_DIV  = CNT_W'(ITERS_DIV - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             last;

  // N-1 fits in CNT_W bits even for N = 2^CNT_W, so no wrap is needed
  assign last = (cnt_q == (mode_q ? LAST_SQRT : LAST_DIV));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    if (in_flush) begin
      state_d = in_start ? S_HOLD : S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_start) begin
            state_d = S_LOAD;
            mode_d  = in_mode;
          end
        end
        S_LOAD: begin
          state_d = S_ITER;
          cnt_d   = '0;
        end
        S_ITER: begin
          if (last) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DONE: state_d = in_start ? S_HOLD : S_IDLE;
        S_HOLD: state_d = in_start ? S_HOLD : S_IDLE;
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge in_Clk or negedge in_Rst_N) begin
    if (!in_Rst_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  assign out_load     = (state_q == S_LOAD);
  assign out_shift_en = (state_q == S_ITER);
  assign out_iter_idx = out_shift_en ? cnt_q : '0;
  assign out_busy     = out_load | out_shift_en;
  assign out_done     = (state_q == S_DONE);
  assign out_mode     = mode_q;

  // Stall is held low during reset and in DONE/HOLD
  assign out_stall = in_Rst_N & in_start & ~in_flush &
                     ((state_q == S_IDLE) | out_busy);

endmodule

// File: tb/tb_fp_iter_seq_ctrl.sv
// Randomised self-checking bench for fp_iter_seq_ctrl with a cycle-timeline
// reference model; extra instances cover ITERS_DIV = 1 and 256.
module tb_fp_iter_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] st, md, fl;
  logic       ld [3];
  logic       sh [3];
  logic       bz [3];
  logic       dn [3];
  logic       stl [3];
  logic       om [3];
  logic [7:0] ix [3];

  int checks = 0;
  int errors = 0;
  logic last_mode = 1'b0;

  always #5 clk = ~clk;

  fp_iter_seq_ctrl u0 (
    .in_Clk(clk), .in_Rst_N(rst_n), .in_start(st[0]), .in_mode(md[0]),
    .in_flush(fl[0]), .out_load(ld[0]), .out_shift_en(sh[0]),
    .out_iter_idx(ix[0]), .out_busy(bz[0]), .out_done(dn[0]),
    .out_stall(stl[0]), .out_mode(om[0])
  );

  fp_iter_seq_ctrl #(.ITERS_DIV(1)) u1 (
    .in_Clk(clk), .in_Rst_N(rst_n), .in_start(st[1]), .in_mode(md[1]),
    .in_flush(fl[1]), .out_load(ld[1]), .out_shift_en(sh[1]),
    .out_iter_idx(ix[1]), .out_busy(bz[1]), .out_done(dn[1]),
    .out_stall(stl[1]), .out_mode(om[1])
  );

  fp_iter_seq_ctrl #(.ITERS_DIV(256)) u2 (
    .in_Clk(clk), .in_Rst_N(rst_n), .in_start(st[2]), .in_mode(md[2]),
    .in_flush(fl[2]), .out_load(ld[2]), .out_shift_en(sh[2]),
    .out_iter_idx(ix[2]), .out_busy(bz[2]), .out_done(dn[2]),
    .out_stall(stl[2]), .out_mode(om[2])
  );

  // One operation from IDLE: start high for cycles 0..start_len-1,
  // optional flush at cycle flush_at, mode randomised after cycle 0.
  task automatic run_op(input int sel, input logic m, input int start_len,
                        input int flush_at, output int nshift,
                        output int last_idx, output int ndone);
    int n, endc, total;
    logic s, act;
    logic e_ld, e_sh, e_dn, e_bz, e_stl, e_om;
    logic [7:0] e_ix;
    logic [13:0] got, exp_v;
    n = m ? 26 : (sel == 0 ? 27 : (sel == 1 ? 1 : 256));
    endc = (flush_at >= 0) ? flush_at : n + 2;
    total = ((endc > start_len - 1) ? endc : start_len - 1) + 3;
    nshift = 0;
    ndone = 0;
    last_idx = -1;
    for (int c = 0; c < total; c++) begin
      @(negedge clk);
      s = (c < start_len);
      st[sel] = s;
      fl[sel] = (c == flush_at);
      md[sel] = (c == 0) ? m : 1'($urandom_range(0, 1));
      #1;
      act   = (c <= endc);
      e_ld  = act && c == 1;
      e_sh  = act && c >= 2 && c <= n + 1;
      e_ix  = e_sh ? 8'(c - 2) : 8'd0;
      e_dn  = act && c == n + 2;
      e_bz  = e_ld | e_sh;
      e_stl = s && c <= n + 1 && c <= endc && c != flush_at;
      e_om  = (c == 0) ? last_mode : m;
      got   = {ld[sel], sh[sel], ix[sel], bz[sel], dn[sel], stl[sel], om[sel]};
      exp_v = {e_ld, e_sh, e_ix, e_bz, e_dn, e_stl, e_om};
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL outputs sel%0d cyc%0d got %h exp %h", sel, c, got, exp_v);
      end
      if (sh[sel] === 1'b1) begin
        nshift++;
        last_idx = int'(ix[sel]);
      end
      if (dn[sel] === 1'b1) ndone++;
    end
    st[sel] = 1'b0;
    fl[sel] = 1'b0;
    last_mode = m;
  endtask

  task automatic test_reset();
    logic [13:0] got;
    rst_n = 1'b0;
    st = 3'b111;
    md = 3'b000;
    fl = 3'b000;
    repeat (3) @(negedge clk);
    #1;
    got = {ld[0], sh[0], ix[0], bz[0], dn[0], stl[0], om[0]};
    checks++;
    if (got !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp 0", got);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if ({stl[0], ld[0]} !== 2'b10) begin
      errors++;
      $display("FAIL release_stall got %b exp 10", {stl[0], ld[0]});
    end
    @(negedge clk);
    #1;
    checks++;
    if (ld[0] !== 1'b1) begin
      errors++;
      $display("FAIL first_load got %b exp 1", ld[0]);
    end
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if ({sh[0], ix[0]} !== {1'b1, 8'd4}) begin
      errors++;
      $display("FAIL iter_before_reset got %h exp 104", {sh[0], ix[0]});
    end
    rst_n = 1'b0;
    #1;
    got = {ld[0], sh[0], ix[0], bz[0], dn[0], stl[0], om[0]};
    checks++;
    if (got !== 14'd0) begin
      errors++;
      $display("FAIL async_reset got %h exp 0", got);
    end
    st = 3'b000;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    last_mode = 1'b0;
  endtask

  task automatic test_divide();
    int ns, li, nd;
    run_op(0, 1'b0, 40, -1, ns, li, nd);
    checks++;
    if (ns != 27 || li != 26 || nd != 1) begin
      errors++;
      $display("FAIL divide shifts %0d last %0d done %0d exp 27 26 1", ns, li, nd);
    end
  endtask

  task automatic test_sqrt_drop();
    int ns, li, nd;
    run_op(0, 1'b1, 29, -1, ns, li, nd);
    checks++;
    if (ns != 26 || li != 25 || nd != 1) begin
      errors++;
      $display("FAIL sqrt shifts %0d last %0d done %0d exp 26 25 1", ns, li, nd);
    end
  endtask

  task automatic test_back_to_back();
    int ns, li, nd;
    run_op(0, 1'b0, 5, -1, ns, li, nd);
    checks++;
    if (ns != 27 || nd != 1) begin
      errors++;
      $display("FAIL early_drop shifts %0d done %0d exp 27 1", ns, nd);
    end
    run_op(0, 1'b1, 3, -1, ns, li, nd);
    checks++;
    if (ns != 26 || nd != 1) begin
      errors++;
      $display("FAIL restart shifts %0d done %0d exp 26 1", ns, nd);
    end
  endtask

  task automatic test_flush();
    int ns, li, nd;
    run_op(0, 1'b0, 40, 12, ns, li, nd);
    checks++;
    if (ns != 11 || li != 10 || nd != 0) begin
      errors++;
      $display("FAIL flush shifts %0d last %0d done %0d exp 11 10 0", ns, li, nd);
    end
  endtask

  task automatic test_sweep();
    int ns, li, nd;
    run_op(1, 1'b0, 4, -1, ns, li, nd);
    checks++;
    if (ns != 1 || li != 0 || nd != 1) begin
      errors++;
      $display("FAIL n1 shifts %0d last %0d done %0d exp 1 0 1", ns, li, nd);
    end
    last_mode = 1'b0;
    run_op(2, 1'b0, 300, -1, ns, li, nd);
    checks++;
    if (ns != 256 || li != 255 || nd != 1) begin
      errors++;
      $display("FAIL n256 shifts %0d last %0d done %0d exp 256 255 1", ns, li, nd);
    end
    last_mode = 1'b0;
  endtask

  task automatic test_random();
    int ns, li, nd, n, slen, fa;
    logic m;
    for (int k = 0; k < 8; k++) begin
      m = 1'($urandom_range(0, 1));
      n = m ? 26 : 27;
      slen = $urandom_range(1, n + 6);
      fa = ($urandom_range(0, 2) == 0) ? $urandom_range(1, n + 1) : -1;
      run_op(0, m, slen, fa, ns, li, nd);
      checks++;
      if (nd != ((fa < 0) ? 1 : 0)) begin
        errors++;
        $display("FAIL rand%0d done %0d flush_at %0d", k, nd, fa);
      end
    end
  endtask

  initial begin
    test_reset();
    test_divide();
    test_sqrt_drop();
    test_back_to_back();
    test_flush();
    test_sweep();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_iter_seq_ctrl.md
Name: fp_iter_seq_ctrl

Overview:
- Parametrised sequencing controller for the iterative mantissa datapaths (divide and square root) in the FP unit.
- Sequences load → N shift/iterate cycles → done, with N selected per operation by a mode input.
- Drives the pipeline stall, supports a synchronous flush, and blocks re-triggering while in_start is still held after completion.

Parameters:
ITERS_SQRT, 26, iteration count when in_mode=1 (sqrt); legal range 1..2^CNT_W
ITERS_DIV, 27, iteration count when in_mode=0 (divide); legal range 1..2^CNT_W
CNT_W, 8, width of the iteration counter and of out_iter_idx

Ports:
in_Clk  in  1  clock, rising edge
in_Rst_N  in  1  asynchronous active-low reset
in_start  in  1  level request; held high by the issuing stage until out_stall drops
in_mode  in  1  0=divide, 1=sqrt; sampled only on IDLE→LOAD
in_flush  in  1  synchronous abort (pipeline flush)
out_load  out  1  datapath operand-load strobe
out_shift_en  out  1  datapath iterate/shift enable
out_iter_idx  out  CNT_W  index of the current iteration, 0..N-1
out_busy  out  1  high in LOAD or ITER
out_done  out  1  one-cycle completion pulse; datapath result valid this cycle
out_stall  out  1  pipeline stall request
out_mode  out  1  latched mode of the operation in progress

Behaviour:
- Reset is in_Rst_N, asynchronous, active-low; clock is in_Clk.
- On reset: state=IDLE, counter=0, mode latch=0.
- Reset values of the registered outputs: out_load, out_shift_en, out_busy, out_done = 0; out_iter_idx = 0; out_mode = 0.
- Reset value of out_stall: 0 while reset is asserted. It is in_start-dependent after release.
- States: IDLE, LOAD, ITER, DONE, HOLD. Encoding is binary.
- The FSM counter replaces the per-state enumeration; only a CNT_W-bit counter may grow with N.
- Transitions (in_flush=0):
  - IDLE: in_start=1 → LOAD, latch in_mode; else stay in IDLE.
  - LOAD: → ITER, counter=0.
  - ITER: when counter==N-1 → DONE; else counter+1. N = ITERS_SQRT if the latched mode is 1, else ITERS_DIV.
  - DONE: in_start=1 → HOLD; else → IDLE.
  - HOLD: in_start=0 → IDLE; else stay. No new operation starts until in_start has been seen low.
- Outputs:
  - out_load=1 only in LOAD.
  - out_shift_en=1 only in ITER.
  - out_iter_idx = counter in ITER, 0 otherwise.
  - out_done=1 only in DONE.
  - out_busy=1 in LOAD or ITER.
  - out_mode = latched mode.
- out_stall is combinational: in_start & (IDLE | LOAD | ITER) & ~in_flush. It is 0 in DONE and HOLD.
- Latency with start seen in IDLE at cycle 0:
  - LOAD at cycle 1.
  - ITER at cycles 2..N+1.
  - DONE at cycle N+2.
  - out_stall is high for cycles 0..N+1, i.e. N+2 cycles.
- in_flush has priority over all transitions in every state.
  - Next state = HOLD if in_start=1, else IDLE. Counter is cleared.
  - out_done is not asserted for the aborted operation.
- Mode change mid-operation is ignored; only the latched mode applies.
- in_start dropping during LOAD/ITER does not abort. The operation completes and goes DONE → IDLE.
- N=1 edge case: ITER lasts exactly one cycle with out_iter_idx=0.
- N=2^CNT_W: counter reaches all-ones and compares equal without wrap.
- Reset mid-operation: immediate return to IDLE, outputs go to their reset values asynchronously.

Test Plan:
- Reset held 3 cycles with in_start=1 → all outputs 0. First edge after release enters LOAD; out_stall goes 1 as soon as reset releases.
- Divide, defaults: in_start=1, in_mode=0, held →
  - out_load high at cycle 1.
  - out_shift_en high cycles 2..28 with out_iter_idx 0..26.
  - out_done at cycle 29; out_stall high cycles 0..28.
  - State goes to HOLD while start is held.
- Sqrt with in_start dropped the cycle after DONE → 26 shift cycles, out_done at cycle 28, HOLD → IDLE. A start re-asserted 2 cycles later begins a new LOAD.
- in_mode toggled to 1 during ITER of a divide → still 27 iterations; out_mode stays 0.
- in_flush at out_iter_idx=10 with in_start=1:
  - Next cycle state is HOLD, out_shift_en=0, no out_done.
  - out_stall=0 during the flush cycle and after it.
  - IDLE is re-entered only after in_start goes low.
- Parameter sweep ITERS_DIV=1 and ITERS_DIV=256 with CNT_W=8 → exactly 1 and 256 shift cycles respectively, out_iter_idx last value 0 and 255.
